ram_dist_ctrl: RTL and testbench

Scan sequencer for the 6-entry, 13-bit distance RAM (ram_dist). On start it clears the RAM, then for slots 0..5 in order it triggers one distance measurement, waits for the result with a timeout, saturates the result to 13 bits and writes it into the RAM. It drives the RAM's addr-then-we protocol, which requires addr to be held one cycle with we low before the write cycle. A timed-out slot is written as 0 and flagged in err_mask; busy and a one-cycle done pulse report progress to the top-level FSM.

---
 rtl/ram_dist_ctrl.sv | 125 ++++++++++++
 tb/tb_ram_dist_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dist_ctrl.sv
// rtl/ram_dist_ctrl.sv - scan sequencer that measures each slot and writes the result into the distance RAM
module ram_dist_ctrl #(
  parameter int N_SLOTS        = 6,
  parameter int MEAS_W         = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic               abort,
  output logic               meas_trigger,
  input  logic               meas_done,
  input  logic [MEAS_W-1:0]  meas_value,
  output logic               ram_clear,
  output logic               ram_we,
  output logic [2:0]         ram_addr,
  output logic [12:0]        ram_data,
  output logic               busy,
  output logic               done,
  output logic [N_SLOTS-1:0] err_mask,
  output logic [2:0]         slot
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        SLOT_LAST = 3'(N_SLOTS - 1);
  localparam logic [MEAS_W-1:0] SAT_MAX   = MEAS_W'(13'h1FFF);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_TRIG, S_WAIT, S_SETUP, S_WRITE, S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [12:0]      cap;
  logic [12:0]      meas_sat;

  always_comb begin
    meas_sat = (meas_value > SAT_MAX) ? 13'h1FFF : meas_value[12:0];
  end

  // The capture register only changes on WAIT exit, so it doubles as the held write data.
  assign ram_data = cap;

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cap          <= '0;
      meas_trigger <= 1'b0;
      ram_clear    <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_mask     <= '0;
      slot         <= '0;
    end else begin
      meas_trigger <= 1'b0;
      ram_clear    <= 1'b0;
      ram_we       <= 1'b0;
      done         <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_CLR;
              ram_clear <= 1'b1;
              busy      <= 1'b1;
              err_mask  <= '0;
              slot      <= '0;
            end
          end
          S_CLR: begin
            state        <= S_TRIG;
            meas_trigger <= 1'b1;
          end
          S_TRIG: begin
            state <= S_WAIT;
            cnt   <= '0;
          end
          S_WAIT: begin
            cnt <= cnt + 1'b1;
            // A response on the last allowed cycle still counts as a good measurement.
            if (meas_done) begin
              cap      <= meas_sat;
              ram_addr <= slot;
              state    <= S_SETUP;
            end else if (cnt == CNT_LAST) begin
              cap            <= '0;
              err_mask[slot] <= 1'b1;
              ram_addr       <= slot;
              state          <= S_SETUP;
            end
          end
          S_SETUP: begin
            state  <= S_WRITE;
            ram_we <= 1'b1;
          end
          S_WRITE: begin
            if (slot == SLOT_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              slot         <= slot + 1'b1;
              state        <= S_TRIG;
              meas_trigger <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dist_ctrl.sv
// tb/tb_ram_dist_ctrl.sv - randomized self-checking bench for ram_dist_ctrl against a scan-level model
module tb_ram_dist_ctrl;

  localparam int N = 6;
  localparam int W = 16;
  localparam int T = 20;

  logic          clk = 1'b0;
  logic          clear = 1'b1, start = 1'b0, abort = 1'b0, meas_done = 1'b0;
  logic [W-1:0]  meas_value = '0;
  logic          meas_trigger, ram_clear, ram_we, busy, done;
  logic [2:0]    ram_addr, slot;
  logic [12:0]   ram_data;
  logic [N-1:0]  err_mask;

  ram_dist_ctrl #(.N_SLOTS(N), .MEAS_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .clear(clear), .start(start), .abort(abort),
    .meas_trigger(meas_trigger), .meas_done(meas_done), .meas_value(meas_value),
    .ram_clear(ram_clear), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .done(done), .err_mask(err_mask), .slot(slot)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sensor plan per slot: dly=0 means never answers.
  int           dly [N];
  logic [W-1:0] val [N];
  logic [12:0]  mem [N];
  logic [12:0]  exp_mem [N];
  logic [N-1:0] exp_err;
  int           exp_done_cyc;

  int cyc, pend, trig_idx, resp_idx, we_cnt, done_cnt, done_cyc, trig_cnt;
  logic        prev_we;
  logic [2:0]  prev_addr;
  logic [12:0] prev_data;

  task automatic build_model();
    int sum = 0;
    exp_err = '0;
    for (int i = 0; i < N; i++) begin
      if (dly[i] >= 1 && dly[i] <= T) begin
        exp_mem[i] = (val[i] > 8191) ? 13'h1FFF : val[i][12:0];
        sum += dly[i] + 3;
      end else begin
        exp_mem[i] = 13'd0;
        exp_err[i] = 1'b1;
        sum += T + 3;
      end
    end
    exp_done_cyc = 2 + sum;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ram_clear) for (int i = 0; i < N; i++) mem[i] = 13'd0;
    if (ram_we) begin
      we_cnt++;
      check("setup_before_we", {prev_we, prev_addr, prev_data}, {1'b0, ram_addr, ram_data});
      if (ram_addr < N) mem[ram_addr] = ram_data;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_we   = ram_we;
    prev_addr = ram_addr;
    prev_data = ram_data;
    meas_done  = 1'b0;
    meas_value = W'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        meas_done  = 1'b1;
        meas_value = val[resp_idx];
      end
    end
    if (meas_trigger) begin
      trig_cnt++;
      resp_idx = (trig_idx < N) ? trig_idx : N - 1;
      pend     = (trig_idx < N) ? dly[trig_idx] : 0;
      trig_idx++;
    end
  endtask

  task automatic begin_scan();
    pend = 0; trig_idx = 0; resp_idx = 0; we_cnt = 0; done_cnt = 0; done_cyc = -1; trig_cnt = 0;
    build_model();
    cyc   = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("clr_pulse", ram_clear, 1);
    check("busy_clr", busy, 1);
  endtask

  task automatic run_scan(input bit noise_start);
    int guard = 0;
    begin_scan();
    while (done_cnt == 0 && guard < 3000) begin
      if (noise_start) start = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    start = 1'b0;
    check("scan_finished", guard < 3000, 1);
    step();
    step();
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, exp_done_cyc);
    check("we_count", we_cnt, N);
    check("trig_count", trig_cnt, N);
    check("err_mask", err_mask, exp_err);
    check("busy_idle", busy, 0);
    for (int i = 0; i < N; i++) check($sformatf("ram_q%0d", i), mem[i], exp_mem[i]);
  endtask

  task automatic random_plan();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       dly[i] = 0;
        1:       dly[i] = $urandom_range(T - 1, T + 4);
        default: dly[i] = $urandom_range(1, 6);
      endcase
      val[i] = W'($urandom);
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < N; i++) mem[i] = 13'd0;
    prev_we = 1'b0; prev_addr = '0; prev_data = '0;
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    check("reset_outputs",
          {meas_trigger, ram_clear, ram_we, ram_addr, ram_data, busy, done, err_mask, slot}, 0);

    // Normal scan with values 100..600, start pulsed randomly while busy.
    for (int i = 0; i < N; i++) begin
      dly[i] = 3;
      val[i] = W'((i + 1) * 100);
    end
    run_scan(1'b1);

    // Saturation boundaries.
    random_plan();
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 5);
    val[2] = 16'h4000;
    val[3] = 16'd8191;
    val[4] = 16'd8192;
    run_scan(1'b0);

    // Timeout on slot 4, tie on slot 1 (answer on the final allowed cycle).
    for (int i = 0; i < N; i++) begin
      dly[i] = 2;
      val[i] = W'($urandom_range(0, 8191));
    end
    dly[4] = 0;
    dly[1] = T;
    val[1] = 16'd77;
    run_scan(1'b0);
    check("timeout_mask_literal", err_mask, 6'b010000);

    for (int r = 0; r < 4; r++) begin
      random_plan();
      run_scan(1'b0);
    end

    // Abort while waiting on slot 3.
    for (int i = 0; i < N; i++) begin
      dly[i] = 3;
      val[i] = W'($urandom);
    end
    begin_scan();
    guard = 0;
    while (trig_idx < 4 && guard < 500) begin
      step();
      guard++;
    end
    check("abort_reach_slot3", guard < 500, 1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_no_we", ram_we, 0);
    for (int i = 0; i < 40; i++) step();
    check("abort_no_done", done_cnt, 0);
    check("abort_trig_count", trig_cnt, 4);
    check("abort_we_count", we_cnt, 3);
    for (int i = 0; i < N; i++)
      check($sformatf("abort_q%0d", i), mem[i], (i < 3) ? exp_mem[i] : 13'd0);

    // Synchronous clear during WRITE of slot 1, then a clean scan.
    random_plan();
    begin_scan();
    guard = 0;
    while (!(ram_we && ram_addr == 3'd1) && guard < 500) begin
      step();
      guard++;
    end
    check("clear_reach_write1", guard < 500, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_outputs",
          {meas_trigger, ram_clear, ram_we, ram_addr, ram_data, busy, done, err_mask, slot}, 0);
    for (int i = 0; i < 3; i++) step();
    random_plan();
    run_scan(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
